decoder_scan: RTL
=================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 3, width of the binary select.
REQ-002 Parameter DWELL_W, default 8, width of the scan dwell count.
REQ-003 Derived constant OUT_N = 2**SEL_W, the number of one-hot outputs (default 8).
REQ-004 Port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 Port rst, input, 1, reset, synchronous and active-high.
REQ-006 Port en, input, 1, block enable; when low, all outputs are forced inactive.
REQ-007 Port mode, input, 1, 0 = direct decode, 1 = auto-scan.
REQ-008 Port sel, input, SEL_W, binary select used in direct mode.
REQ-009 Port sel_valid, input, 1, qualifies sel; sel is sampled only when high.
REQ-010 Port dwell, input, DWELL_W, number of extra cycles each scan position is held.
REQ-011 Port out, output, OUT_N, registered one-hot decode; bit k active means position k.
REQ-012 Port out_valid, output, 1, high whenever out holds a valid one-hot value.
REQ-013 Port index, output, SEL_W, binary index of the active out bit.
REQ-014 Port wrap, output, 1, single-cycle pulse when the scan returns from OUT_N-1 to 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, DIRECT and SCAN.
REQ-016 From any state, en=0 SHALL move to IDLE; IDLE drives out=0, out_valid=0 and wrap=0, and holds index.
REQ-017 With en=1 and mode=0, the FSM SHALL move to DIRECT; with en=1 and mode=1, it SHALL move to SCAN.
REQ-018 In DIRECT, when sel_valid=1, out = 1<<sel, index = sel and out_valid = 1 on the next edge (latency 1 cycle).
REQ-019 In DIRECT, when sel_valid=0, out, index and out_valid SHALL hold their last values.
REQ-020 Entering DIRECT from IDLE, out_valid SHALL stay 0 until the first sel_valid.
REQ-021 Entering SCAN from any other state SHALL set index=0, out=1, out_valid=1 and clear the dwell counter, all on the next edge.
REQ-022 In SCAN, each position SHALL be held for dwell+1 cycles; dwell=0 advances every cycle.
REQ-023 At the end of a hold period, index SHALL increment modulo OUT_N and out SHALL become 1<<index.
REQ-024 On the advance from OUT_N-1 to 0, wrap SHALL be 1 for exactly the cycle in which index=0 first appears; otherwise wrap=0.
REQ-025 A change of dwell during SCAN SHALL take effect from the next hold comparison; the counter is not reset.
REQ-026 A mode change with en=1 SHALL switch state on the next edge; SCAN to DIRECT holds out until the first sel_valid.
REQ-027 out SHALL always be all-zero or exactly one-hot; out_valid=1 implies one-hot.

Reset
REQ-028 rst=1 on a clock edge SHALL force state=IDLE, out=0, out_valid=0, index=0, wrap=0 and the dwell counter to 0.
REQ-029 rst SHALL take priority over en, mode and sel_valid, including mid-scan.

Configuration
REQ-030 The scan feature SHALL be controlled by the macro DECODER_SCAN_EN.
REQ-031 With DECODER_SCAN_EN defined, the block behaves fully as specified above.
REQ-032 Without DECODER_SCAN_EN, the SCAN state and dwell counter SHALL be absent, mode is ignored (treated as 0), dwell is unused, and wrap is tied to 0.

Structure
REQ-033 Package decoder_pkg SHALL hold the state enum (IDLE, DIRECT, SCAN) and the mode constants MODE_DIRECT=0 and MODE_SCAN=1.
REQ-034 Sub-module decoder_dwell_timer SHALL implement the DWELL_W-bit hold counter with clear input and expire output; it is instantiated only under DECODER_SCAN_EN.

Verification
REQ-035 Reset: assert rst with en=1, mode=1 mid-scan -> next cycle out=0, out_valid=0, index=0, wrap=0.
REQ-036 Direct: en=1, mode=0, sel=5, sel_valid=1 -> one cycle later out=8'b0010_0000, index=5, out_valid=1; drop sel_valid, change sel=2 -> out unchanged.
REQ-037 Scan timing: mode=1, dwell=2 -> out=0x01 for 3 cycles, then 0x02 for 3 cycles, and so on; wrap pulses once when 0x80 returns to 0x01 (every 24 cycles).
REQ-038 dwell=0 scan: out steps 0x01, 0x02, ..., 0x80, 0x01 on consecutive cycles; wrap=1 only with the second 0x01.
REQ-039 Disable and mode switch: en=0 mid-scan -> out=0 next cycle; en=1, mode=1 -> restart at 0x01; switch to mode=0 -> out holds until sel_valid.
REQ-040 Build without DECODER_SCAN_EN; drive mode=1 with sel=3 valid -> out=0x08, and wrap stays 0 for 100 cycles.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder_scan block.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_dwell_timer.sv
// Hold counter for scan positions: expire is high on the last cycle of each hold period.
module decoder_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;

  // Compared against the live dwell so a shortened dwell expires at once.
  assign expire = (cnt >= dwell);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Binary-to-one-hot decoder with optional auto-scan mode.
// Auto-scan (SCAN state, dwell timer, wrap pulse) is built only with DECODER_SCAN_EN.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 8,
  localparam int OUT_N   = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_N-1:0]   out,
  output logic               out_valid,
  output logic [SEL_W-1:0]   index,
  output logic               wrap
);

  state_t state;

`ifdef DECODER_SCAN_EN
  logic             expire;
  logic             scan_hold;
  logic [SEL_W-1:0] next_index;

  // Timer only runs while an established scan continues; any other path clears it.
  assign scan_hold  = (state == SCAN) && en && (mode == MODE_SCAN);
  assign next_index = index + 1'b1;

  decoder_dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear (!scan_hold),
    .dwell (dwell),
    .expire(expire)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, dwell, state};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      index     <= '0;
      wrap      <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
`ifdef DECODER_SCAN_EN
    end else if (mode == MODE_SCAN) begin
      state <= SCAN;
      if (state != SCAN) begin
        index     <= '0;
        out       <= OUT_N'(1);
        out_valid <= 1'b1;
        wrap      <= 1'b0;
      end else if (expire) begin
        index <= next_index;
        out   <= OUT_N'(1) << next_index;
        wrap  <= (index == '1);
      end else begin
        wrap <= 1'b0;
      end
`endif
    end else begin
      state <= DIRECT;
      wrap  <= 1'b0;
      if (sel_valid) begin
        out       <= OUT_N'(1) << sel;
        index     <= sel;
        out_valid <= 1'b1;
      end
    end
  end

endmodule
